pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller for a 5-stage pipeline: memory-wait stalls, mispredict
// flushes, load-use bubbles, halting, dmem timeout and a saturating stall counter.
module pipeline_stall_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_use_hazard,
    input  logic                 mispredict,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    input  logic                 halt_req,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 mem_wb_bubble,
    output logic                 dmem_req,
    output logic                 is_halted,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // The MEM_WAIT cycle that would bring the count up to TIMEOUT_CYCLES.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [WAIT_W-1:0]      wait_cnt_reg;
    logic [CNT_WIDTH-1:0]   stall_count_reg;
    logic                   mem_timeout_reg;
    logic                   is_halted_reg;
    logic                   mem_stall;
    logic                   timeout_hit;

    always_comb begin
        state_next    = state_reg;
        mem_stall     = 1'b0;
        timeout_hit   = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        dmem_req      = 1'b0;

        case (state_reg)
            RUN: begin
                dmem_req  = mem_access;
                mem_stall = mem_access && !dmem_ready;
                if (mem_stall)
                    state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                dmem_req  = 1'b1;
                mem_stall = !dmem_ready;
                if (dmem_ready) begin
                    state_next = RUN;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = HALT;
                end
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end
        endcase

        // Priority: memory stall, then mispredict, then load-use.
        if (state_reg != HALT) begin
            if (mem_stall) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (mispredict) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use_hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            if (halt_req)
                state_next = HALT;
        end

        // Outputs are forced to a quiet, free-running pattern while reset is held.
        if (reset) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
            dmem_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            stall_count_reg <= '0;
            mem_timeout_reg <= 1'b0;
            is_halted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            is_halted_reg <= (state_next == HALT);
            if (timeout_hit)
                mem_timeout_reg <= 1'b1;
            // Zero on every entry to MEM_WAIT, count while staying there.
            if (state_reg == MEM_WAIT && state_next == MEM_WAIT)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;
            if (state_reg != HALT && !pc_write && stall_count_reg != '1)
                stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign is_halted   = is_halted_reg;
    assign mem_timeout = mem_timeout_reg;
    assign stall_count = stall_count_reg;

endmodule
